// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit sequencer (start bit, DATA_W bits LSB-first, stop bit).
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_ctrl #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int BAUD_W       = 5,
    parameter int IDX_W        = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t              state, state_nxt;
    logic [BAUD_W-1:0]   baud_cnt, baud_nxt;
    logic [IDX_W-1:0]    bit_idx, idx_nxt;
    logic [DATA_W-1:0]   shift_reg, shift_nxt;
    logic                tx_nxt, busy_nxt, done_nxt;
    logic                baud_tick, last_bit;
`ifdef UART_PARITY_EN
    logic                parity_bit, parity_nxt;
`endif

    assign baud_tick = (state != IDLE) && (baud_cnt == BAUD_MAX);
    assign last_bit  = (bit_idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            baud_cnt   <= baud_nxt;
            bit_idx    <= idx_nxt;
            shift_reg  <= shift_nxt;
            tx         <= tx_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
`ifdef UART_PARITY_EN
            parity_bit <= parity_nxt;
`endif
        end
    end

    // tx is registered, so each transition loads the level of the bit being entered
    always_comb begin
        state_nxt  = state;
        baud_nxt   = baud_cnt;
        idx_nxt    = bit_idx;
        shift_nxt  = shift_reg;
        tx_nxt     = tx;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
`ifdef UART_PARITY_EN
        parity_nxt = parity_bit;
`endif

        if (state != IDLE) begin
            baud_nxt = baud_tick ? '0 : baud_cnt + BAUD_W'(1);
        end

        case (state)
            IDLE: begin
                if (start) begin
                    shift_nxt  = data_in;
`ifdef UART_PARITY_EN
                    parity_nxt = ^data_in;
`endif
                    state_nxt  = START;
                    tx_nxt     = 1'b0;
                    busy_nxt   = 1'b1;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_nxt = DATA;
                    tx_nxt    = shift_reg[0];
                end
            end
            DATA: begin
                if (baud_tick) begin
                    idx_nxt = bit_idx + IDX_W'(1);
                    if (last_bit) begin
`ifdef UART_PARITY_EN
                        state_nxt = PARITY;
                        tx_nxt    = parity_bit;
`else
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        shift_nxt = shift_reg >> 1;
                        tx_nxt    = shift_reg[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase

        if (state_nxt != state) begin
            baud_nxt = '0;
        end
        if (state_nxt == DATA && state != DATA) begin
            idx_nxt = '0;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed and randomized frames checked every cycle against a frame-position model.
// Build with UART_PARITY_EN defined to exercise the parity variant.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

    localparam int DATA_W = 8;
    localparam int CPB    = 16;
`ifdef UART_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME = (DATA_W + 2 + PAR_BITS) * CPB;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        tx, busy, done;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          edge_cnt = 0;
    int          t0       = 0;

    // Model: position within the current frame, counted in clock edges since acceptance
    bit          m_active = 1'b0;
    int          m_pos    = 0;
    logic [7:0]  m_data   = 8'h00;

    uart_tx_ctrl #(
        .DATA_W(DATA_W),
        .CLKS_PER_BIT(CPB),
        .BAUD_W(5),
        .IDX_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .data_in(data_in),
        .tx(tx),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_pos    = 0;
        end else if ((!m_active || m_pos == FRAME + 1) && start) begin
            m_active = 1'b1;
            m_pos    = 1;
            m_data   = data_in;
        end else if (m_active) begin
            m_pos++;
            if (m_pos > FRAME + 1) m_active = 1'b0;
        end
    end

    // Expected {tx, busy, done} from the frame layout: start, data LSB-first, [parity], stop
    function automatic logic [2:0] model_out();
        int         b;
        logic [7:0] sh;
        if (m_active && m_pos >= 1 && m_pos <= FRAME) begin
            b = (m_pos - 1) / CPB;
            if (b == 0) return 3'b010;
            if (b <= DATA_W) begin
                sh = m_data >> (b - 1);
                return {sh[0], 2'b10};
            end
            if (PAR_BITS == 1 && b == DATA_W + 1) return {^m_data, 2'b10};
            return 3'b110;
        end
        return {1'b1, 1'b0, (m_active && m_pos == FRAME + 1)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
    endtask

    always begin
        @(posedge clk);
        #3;
        checkOutput("cycle_outputs", {29'd0, tx, busy, done}, {29'd0, model_out()});
    end

    // Advance to the falling edge inside cycle c of the frame accepted at edge t0
    task automatic go_cycle(input int c);
        do @(negedge clk); while (edge_cnt < t0 + c - 1);
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        t0      = edge_cnt + 1;
        @(negedge clk);
        start   = 1'b0;
        data_in = 8'($urandom);
    endtask

    task automatic capture_frame(input int last_cycle, input int poke_cycle,
                                 output logic [7:0] got, output int n_done, output int done_at);
        got     = 8'h00;
        n_done  = 0;
        done_at = -1;
        for (int c = 2; c <= last_cycle; c++) begin
            go_cycle(c);
            if (c >= 24 && c <= 24 + 16 * 7 && (c - 24) % 16 == 0) got = {tx, got[7:1]};
            if (done) begin
                n_done++;
                done_at = c;
            end
            if (poke_cycle != 0 && c == poke_cycle) begin
                start   = 1'b1;
                data_in = 8'hFF;
            end
            if (poke_cycle != 0 && c == poke_cycle + 1) start = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] got;
        int         n_done, done_at;
        int         a5_seq[$];
`ifdef UART_PARITY_EN
        a5_seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
        a5_seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif

        $display("[TB] reset behaviour");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start   = ~start;
            data_in = 8'($urandom);
            checkOutput("reset_hold", {29'd0, tx, busy, done}, 32'b100);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        checkOutput("post_reset_idle", {29'd0, tx, busy, done}, 32'b100);

        $display("[TB] single frame 0xA5");
        applyStimulus(8'hA5);
        foreach (a5_seq[i]) begin
            go_cycle(8 + 16 * i);
            checkOutput("a5_midbit", {31'd0, tx}, a5_seq[i]);
        end
        go_cycle(FRAME);
        checkOutput("a5_last_busy", {30'd0, busy, done}, 32'b10);
        go_cycle(FRAME + 1);
        checkOutput("a5_done", {30'd0, busy, done}, 32'b01);
        go_cycle(FRAME + 2);
        checkOutput("a5_done_clear", {31'd0, done}, 32'd0);

        $display("[TB] start while busy");
        applyStimulus(8'h3C);
        capture_frame(FRAME + 3, 40, got, n_done, done_at);
        checkOutput("busy_reject_data", {24'd0, got}, 32'h3C);
        checkOutput("busy_reject_ndone", n_done, 32'd1);
        checkOutput("busy_reject_done_at", done_at, FRAME + 1);

        $display("[TB] back-to-back frames");
        @(negedge clk);
        start   = 1'b1;
        data_in = 8'h55;
        t0      = edge_cnt + 1;
        go_cycle(FRAME + 1);
        checkOutput("b2b_done", {29'd0, tx, busy, done}, 32'b101);
        go_cycle(FRAME + 2);
        checkOutput("b2b_restart", {30'd0, tx, busy}, 32'b01);
        t0 = t0 + FRAME + 1;
        capture_frame(FRAME, 0, got, n_done, done_at);
        checkOutput("b2b_second_data", {24'd0, got}, 32'h55);
        go_cycle(FRAME + 1);
        start = 1'b0;
        checkOutput("b2b_second_done", {31'd0, done}, 32'd1);
        repeat (20) @(negedge clk);

        $display("[TB] reset mid-frame");
        applyStimulus(8'h0F);
        go_cycle(70);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_immediate", {29'd0, tx, busy, done}, 32'b100);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h81);
        capture_frame(FRAME + 2, 0, got, n_done, done_at);
        checkOutput("after_abort_data", {24'd0, got}, 32'h81);
        checkOutput("after_abort_done_at", done_at, FRAME + 1);

`ifdef UART_PARITY_EN
        $display("[TB] parity of 0x01");
        applyStimulus(8'h01);
        go_cycle(8 + 16 * 9);
        checkOutput("parity_01", {31'd0, tx}, 32'd1);
        go_cycle(FRAME + 1);
        checkOutput("parity_done_at", {31'd0, done}, 32'd1);
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start   = ($urandom_range(0, 5) == 0);
            data_in = 8'($urandom);
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (FRAME + 5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
